// File: rtl/sha256_msg_schedule.sv
// sha256_msg_schedule: SHA-256 message schedule and round sequencer for the compression core.
// Optional SCHED_PIPE_EN registers the round outputs and delays block_done by one cycle.
module sha256_msg_schedule #(
    parameter int ROUNDS = 64,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              block_valid,
    output logic              block_ready,
    input  logic [511:0]      block_data,
    output logic [WORD_W-1:0] w_t,
    output logic [WORD_W-1:0] k_t,
    output logic [5:0]        t_idx,
    output logic              round_init,
    output logic              hold_h,
    output logic              last_round,
    output logic              block_done
);
    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
    localparam logic [WORD_W-1:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    state_t            state;
    logic [5:0]        t;
    logic [WORD_W-1:0] win [16];
    logic [WORD_W-1:0] s0, s1, w_next, w_c, k_c;
    logic [5:0]        t_c;
    logic              in_round, in_done, init_c, hold_c, last_c;

    // win[0] is W_t; the word shifted in at win[15] is W_(t+16)
    assign s0       = rotr(win[1], 7) ^ rotr(win[1], 18) ^ (win[1] >> 3);
    assign s1       = rotr(win[14], 17) ^ rotr(win[14], 19) ^ (win[14] >> 10);
    assign w_next   = s1 + win[9] + s0 + win[0];
    assign in_round = state == ROUND;
    assign in_done  = state == DONE;

    always_comb begin
        w_c    = in_round ? win[0] : '0;
        k_c    = in_round ? K[t] : '0;
        t_c    = in_round ? t : '0;
        init_c = in_round && t == 6'd0;
        hold_c = (in_round && t != 6'd0) || in_done;
        last_c = in_round && t == 6'(ROUNDS - 1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            t     <= '0;
        end else if (state == IDLE && block_valid && block_ready) begin
            state <= ROUND;
            t     <= '0;
            for (int i = 0; i < 16; i++) win[i] <= block_data[511-32*i -: 32];
        end else if (in_round) begin
            for (int i = 0; i < 15; i++) win[i] <= win[i+1];
            win[15] <= w_next;
            t       <= t + 6'd1;
            state   <= t == 6'(ROUNDS - 1) ? DONE : ROUND;
        end else if (in_done) begin
            state <= IDLE;
        end
    end

`ifdef SCHED_PIPE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            w_t        <= '0;
            k_t        <= '0;
            t_idx      <= '0;
            round_init <= 1'b0;
            hold_h     <= 1'b0;
            last_round <= 1'b0;
            block_done <= 1'b0;
        end else begin
            w_t        <= w_c;
            k_t        <= k_c;
            t_idx      <= t_c;
            round_init <= init_c;
            hold_h     <= hold_c;
            last_round <= last_c;
            block_done <= in_done;
        end
    end
    // the delayed done pulse must drain before the next block is taken
    assign block_ready = state == IDLE && !block_done && !reset;
`else
    assign w_t         = w_c;
    assign k_t         = k_c;
    assign t_idx       = t_c;
    assign round_init  = init_c;
    assign hold_h      = hold_c;
    assign last_round  = last_c;
    assign block_done  = in_done;
    assign block_ready = state == IDLE && !reset;
`endif
endmodule

// File: tb/tb_sha256_msg_schedule.sv
// tb_sha256_msg_schedule: scoreboard bench; a reference schedule is queued at each acceptance
// and popped as rounds appear, while a reference compression round builds the digest.
module tb_sha256_msg_schedule;
`ifdef SCHED_PIPE_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam logic [255:0] ABC_DIGEST = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [511:0] ABC_BLOCK  = {32'h61626380, 448'h0, 32'h00000018};

    logic         clk = 1'b0, reset = 1'b1, block_valid = 1'b0, block_ready;
    logic [511:0] block_data = '0;
    logic [31:0]  w_t, k_t;
    logic [5:0]   t_idx;
    logic         round_init, hold_h, last_round, block_done;

    sha256_msg_schedule dut (
        .clk(clk), .reset(reset), .block_valid(block_valid), .block_ready(block_ready),
        .block_data(block_data), .w_t(w_t), .k_t(k_t), .t_idx(t_idx), .round_init(round_init),
        .hold_h(hold_h), .last_round(last_round), .block_done(block_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] w;
        int          t;
        int          cyc;
    } exp_t;

    exp_t        w_q[$];
    int          done_q[$];
    int          acc_cyc[$];
    int          total = 0, bad = 0, cyc = 0, acc_cnt = 0, done_cnt = 0, last_t = -1;
    int          cnt_init = 0, cnt_last = 0, cnt_hold = 0, cnt_done = 0, cnt_busy = 0;
    logic [31:0] obs_w [64];
    logic [31:0] obs_k [64];
    logic [31:0] hs [8];
    logic [31:0] iv [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                            32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    logic [255:0] digest = '0;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic push_block(input logic [511:0] d, input int e0);
        logic [31:0] w [64];
        for (int i = 0; i < 64; i++) begin
            w[i] = i < 16 ? d[511-32*i -: 32] : ssig1(w[i-2]) + w[i-7] + ssig0(w[i-15]) + w[i-16];
            w_q.push_back('{w[i], i, e0 + i + P});
        end
        done_q.push_back(e0 + 64 + P);
        acc_cyc.push_back(e0);
        acc_cnt++;
    endtask

    task automatic core_round();
        logic [31:0] t1, t2;
        t1 = hs[7] + (rotr(hs[4], 6) ^ rotr(hs[4], 11) ^ rotr(hs[4], 25))
           + ((hs[4] & hs[5]) ^ (~hs[4] & hs[6])) + k_t + w_t;
        t2 = (rotr(hs[0], 2) ^ rotr(hs[0], 13) ^ rotr(hs[0], 22))
           + ((hs[0] & hs[1]) ^ (hs[0] & hs[2]) ^ (hs[1] & hs[2]));
        for (int i = 7; i > 0; i--) hs[i] = hs[i-1];
        hs[4] = hs[4] + t1;
        hs[0] = t1 + t2;
    endtask

    task automatic monitor();
        exp_t e;
        int   d;
        logic active;
        active   = round_init || (hold_h && !block_done);
        last_t   = active ? int'(t_idx) : -1;
        cnt_init += int'(round_init);
        cnt_last += int'(last_round);
        cnt_hold += int'(hold_h);
        cnt_done += int'(block_done);
        if (!block_ready && !reset) cnt_busy++;
        if (active) begin
            total++;
            if (w_q.size() == 0) begin
                bad++;
                $display("FAIL round_unexpected: got t_idx=%0d cyc=%0d, expected no round", t_idx, cyc);
            end else begin
                e = w_q.pop_front();
                if ({cyc, w_t, int'(t_idx), round_init, last_round} !==
                    {e.cyc, e.w, e.t, e.t == 0, e.t == 63}) begin
                    bad++;
                    $display("FAIL round_%0d: got cyc=%0d w=%h t=%0d init=%b last=%b, expected cyc=%0d w=%h init=%b last=%b",
                             e.t, cyc, w_t, t_idx, round_init, last_round, e.cyc, e.w, e.t == 0, e.t == 63);
                end
            end
            if (round_init) hs = iv;
            obs_w[t_idx] = w_t;
            obs_k[t_idx] = k_t;
            core_round();
        end
        if (block_done) begin
            total++;
            d = done_q.size() > 0 ? done_q.pop_front() : -1;
            if (cyc !== d) begin
                bad++;
                $display("FAIL block_done_cycle: got %0d, expected %0d", cyc, d);
            end
            for (int i = 0; i < 8; i++) digest[255-32*i -: 32] = iv[i] + hs[i];
            done_cnt++;
        end
    endtask

    task automatic tick();
        #1;
        if (reset) begin
            w_q.delete();
            done_q.delete();
        end else if (block_valid && block_ready) begin
            push_block(block_data, cyc + 1);
        end
        @(posedge clk);
        cyc++;
        #1;
        @(negedge clk);
        monitor();
    endtask

    task automatic send(input logic [511:0] d);
        int start;
        start       = acc_cnt;
        block_data  = d;
        block_valid = 1'b1;
        for (int i = 0; i < 200 && acc_cnt == start; i++) tick();
        block_valid = 1'b0;
        total++;
        if (acc_cnt == start) begin
            bad++;
            $display("FAIL accept_timeout: got no acceptance, expected one");
        end
    endtask

    task automatic wait_done();
        int start;
        start = done_cnt;
        for (int i = 0; i < 100 && done_cnt == start; i++) tick();
        total++;
        if (done_cnt == start) begin
            bad++;
            $display("FAIL done_timeout: got no block_done, expected one");
        end
    endtask

    task automatic rand_data();
        for (int j = 0; j < 16; j++) block_data[32*j +: 32] = $urandom();
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        block_valid = 1'b1;
        block_data  = ABC_BLOCK;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({block_ready, w_t, k_t, t_idx, round_init, hold_h, last_round, block_done} !== '0) begin
                bad++;
                $display("FAIL reset_outputs: got ready=%b w=%h k=%h t=%0d init=%b hold=%b last=%b done=%b, expected all 0",
                         block_ready, w_t, k_t, t_idx, round_init, hold_h, last_round, block_done);
            end
        end
        reset       = 1'b0;
        block_valid = 1'b0;
        tick();
        total++;
        if (block_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready: got %b, expected 1", block_ready);
        end
        tick();
        total++;
        if (w_q.size() != 0 || round_init !== 1'b0) begin
            bad++;
            $display("FAIL reset_no_accept: got queued=%0d init=%b, expected 0 0", w_q.size(), round_init);
        end
    endtask

    task automatic test_abc();
        logic [31:0] spot_w [4] = '{32'h61626380, 32'h00000018, 32'h61626380, 32'h000F0000};
        int          spot_i [4] = '{0, 15, 16, 17};
        for (int i = 0; i < 64; i++) begin
            obs_w[i] = '0;
            obs_k[i] = '0;
        end
        digest = '0;
        send(ABC_BLOCK);
        wait_done();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (obs_w[spot_i[i]] !== spot_w[i]) begin
                bad++;
                $display("FAIL abc_w%0d: got %h, expected %h", spot_i[i], obs_w[spot_i[i]], spot_w[i]);
            end
        end
        total++;
        if ({obs_k[0], obs_k[63]} !== {32'h428a2f98, 32'hc67178f2}) begin
            bad++;
            $display("FAIL abc_k: got k0=%h k63=%h, expected 428a2f98 c67178f2", obs_k[0], obs_k[63]);
        end
        total++;
        if (digest !== ABC_DIGEST) begin
            bad++;
            $display("FAIL abc_digest: got %h, expected %h", digest, ABC_DIGEST);
        end
    endtask

    task automatic test_control();
        logic [511:0] d;
        for (int j = 0; j < 16; j++) d[32*j +: 32] = $urandom();
        cnt_init = 0;
        cnt_last = 0;
        cnt_hold = 0;
        cnt_done = 0;
        cnt_busy = 0;
        send(d);
        wait_done();
        repeat (3) tick();
        total++;
        if ({cnt_init, cnt_last, cnt_done, cnt_hold, cnt_busy} !== {32'd1, 32'd1, 32'd1, 32'd64, 32'(65 + P)}) begin
            bad++;
            $display("FAIL control_widths: got init=%0d last=%0d done=%0d hold=%0d busy=%0d, expected 1 1 1 64 %0d",
                     cnt_init, cnt_last, cnt_done, cnt_hold, cnt_busy, 65 + P);
        end
    endtask

    task automatic test_back_to_back();
        int start, n;
        start       = acc_cnt;
        block_valid = 1'b1;
        for (int i = 0; i < 400 && acc_cnt < start + 3; i++) begin
            rand_data();
            tick();
        end
        block_valid = 1'b0;
        n = acc_cyc.size();
        total++;
        if (acc_cnt != start + 3) begin
            bad++;
            $display("FAIL b2b_accepts: got %0d, expected 3", acc_cnt - start);
        end else if (acc_cyc[n-1] - acc_cyc[n-2] != 66 + P || acc_cyc[n-2] - acc_cyc[n-3] != 66 + P) begin
            bad++;
            $display("FAIL b2b_spacing: got %0d %0d, expected %0d", acc_cyc[n-2] - acc_cyc[n-3],
                     acc_cyc[n-1] - acc_cyc[n-2], 66 + P);
        end
        for (int i = 0; i < 100 && (w_q.size() != 0 || done_q.size() != 0); i++) tick();
        total++;
        if (w_q.size() != 0 || done_q.size() != 0) begin
            bad++;
            $display("FAIL b2b_drain: got %0d rounds %0d dones pending, expected 0 0", w_q.size(), done_q.size());
        end
    endtask

    task automatic test_mid_reset();
        int start;
        send(ABC_BLOCK);
        for (int i = 0; i < 80 && last_t != 30; i++) tick();
        reset = 1'b1;
        tick();
        total++;
        if ({block_ready, w_t, k_t, t_idx, round_init, hold_h, last_round, block_done} !== '0) begin
            bad++;
            $display("FAIL midreset_outputs: got ready=%b w=%h t=%0d hold=%b done=%b, expected all 0",
                     block_ready, w_t, t_idx, hold_h, block_done);
        end
        reset = 1'b0;
        tick();
        total++;
        if ({block_ready, round_init, hold_h} !== 3'b100) begin
            bad++;
            $display("FAIL midreset_idle: got ready=%b init=%b hold=%b, expected 1 0 0", block_ready, round_init, hold_h);
        end
        start = done_cnt;
        repeat (70) tick();
        total++;
        if (done_cnt != start) begin
            bad++;
            $display("FAIL midreset_no_done: got %0d dones, expected 0", done_cnt - start);
        end
        digest = '0;
        send(ABC_BLOCK);
        wait_done();
        total++;
        if (digest !== ABC_DIGEST) begin
            bad++;
            $display("FAIL midreset_digest: got %h, expected %h", digest, ABC_DIGEST);
        end
    endtask

    initial begin
        test_reset();
        test_abc();
        test_control();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
